// File: rtl/ai_scheduler.sv
// ai_scheduler: per-frame sequencer for AI slots sharing one move datapath.
// On each accepted frame tick it walks slots 0..AI_NUM-1 in order. Every
// enabled slot gets one move request. When that request completes, the
// scheduler checks whether the slot's AI sits inside the detect window
// around the hero. At the end of the frame the hit count is published
// on detect_num.
//
// Optional feature: define AI_SCHED_TIMEOUT_EN to abandon a request that
// gets no mv_ack within TMO cycles. An abandoned slot is not counted, and
// the sticky tmo_err flag is set. Without the macro, tmo_err is tied low.
//
// Ports:
//   clk_1       sole clock, rising edge
//   rst         asynchronous active-low reset
//   tick        frame-tick pulse (dropped with overrun while busy)
//   ai_enable   per-slot alive mask
//   hero_x/y    hero position
//   ai_x/y_flat AI positions, slot k at [k*COORD_W +: COORD_W]
//   mv_req      move request, held until mv_ack
//   mv_idx      slot being moved
//   mv_ack      move complete (only honoured while requesting)
//   busy        frame sequencing in progress
//   frame_done  one-cycle end-of-frame pulse
//   overrun     one-cycle pulse, issued the cycle after a dropped tick
//   detect_num  enabled AIs inside the detect window, last frame
//   tmo_err     sticky request-timeout flag
module ai_scheduler #(
  parameter int unsigned AI_NUM  = 4,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned DET_R   = 64,
  parameter int unsigned TMO     = 15
) (
  input  logic                          clk_1,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [AI_NUM-1:0]             ai_enable,
  input  logic [COORD_W-1:0]            hero_x,
  input  logic [COORD_W-1:0]            hero_y,
  input  logic [AI_NUM*COORD_W-1:0]     ai_x_flat,
  input  logic [AI_NUM*COORD_W-1:0]     ai_y_flat,
  output logic                          mv_req,
  output logic [$clog2(AI_NUM)-1:0]     mv_idx,
  input  logic                          mv_ack,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun,
  output logic [$clog2(AI_NUM+1)-1:0]   detect_num,
  output logic                          tmo_err
);

  localparam int unsigned IDX_W  = $clog2(AI_NUM);
  localparam int unsigned CNT_W  = $clog2(AI_NUM + 1);
  localparam int unsigned DIFF_W = COORD_W + 1;

  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(AI_NUM - 1);
  localparam logic [DIFF_W-1:0] DET_LIM   = DIFF_W'(DET_R);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  slot, slot_nxt;
  logic [CNT_W-1:0]  acc, acc_nxt, acc_inc;
  logic              mv_req_nxt;
  logic [IDX_W-1:0]  mv_idx_nxt;
  logic              busy_nxt;
  logic              frame_done_nxt;
  logic              overrun_nxt;
  logic [CNT_W-1:0]  detect_nxt;
  logic              advance;
  logic              hit;

  // Unpack the flat position buses into per-slot arrays.
  logic [COORD_W-1:0] ai_x [AI_NUM];
  logic [COORD_W-1:0] ai_y [AI_NUM];

  for (genvar k = 0; k < AI_NUM; k++) begin : g_unpack
    assign ai_x[k] = ai_x_flat[k*COORD_W +: COORD_W];
    assign ai_y[k] = ai_y_flat[k*COORD_W +: COORD_W];
  end

  // Absolute difference computed one bit wider so it can never wrap.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic [DIFF_W-1:0] ae;
    logic [DIFF_W-1:0] be;
    ae = DIFF_W'(a);
    be = DIFF_W'(b);
    return (ae >= be) ? (ae - be) : (be - ae);
  endfunction

  // Detect-window test for the slot currently being evaluated.
  logic in_window_c;
  assign in_window_c = (abs_diff(ai_x[slot], hero_x) <= DET_LIM) &&
                       (abs_diff(ai_y[slot], hero_y) <= DET_LIM);

`ifdef AI_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_err_nxt;
`else
  // The timeout length has no meaning in this build.
  logic unused_tmo;
  assign unused_tmo = ^32'(TMO);
  assign tmo_err    = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    slot_nxt       = slot;
    acc_nxt        = acc;
    mv_req_nxt     = mv_req;
    mv_idx_nxt     = mv_idx;
    frame_done_nxt = 1'b0;
    detect_nxt     = detect_num;
    advance        = 1'b0;
    hit            = 1'b0;
`ifdef AI_SCHED_TIMEOUT_EN
    tmo_cnt_nxt    = tmo_cnt;
    tmo_err_nxt    = tmo_err;
`endif

    case (state)
      S_IDLE: begin
        if (tick) begin
          state_nxt = S_SCAN;
          slot_nxt  = '0;
          acc_nxt   = '0;
        end
      end
      S_SCAN: begin
        if (ai_enable[slot]) begin
          state_nxt  = S_REQ;
          mv_req_nxt = 1'b1;
          mv_idx_nxt = slot;
`ifdef AI_SCHED_TIMEOUT_EN
          tmo_cnt_nxt = '0;
`endif
        end else begin
          advance = 1'b1;
        end
      end
      S_REQ: begin
        if (mv_ack) begin
          mv_req_nxt = 1'b0;
          advance    = 1'b1;
          hit        = in_window_c;
`ifdef AI_SCHED_TIMEOUT_EN
        end else if (tmo_cnt == TMO_LAST) begin
          // Give up on this slot; it is not counted.
          mv_req_nxt  = 1'b0;
          advance     = 1'b1;
          tmo_err_nxt = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
`endif
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Leave the current slot: next slot, or close the frame.
    acc_inc = acc + CNT_W'(hit);
    if (advance) begin
      acc_nxt = acc_inc;
      if (slot == LAST_SLOT) begin
        state_nxt      = S_DONE;
        frame_done_nxt = 1'b1;
        detect_nxt     = acc_inc;
      end else begin
        state_nxt = S_SCAN;
        slot_nxt  = slot + IDX_W'(1);
      end
    end

    busy_nxt    = (state_nxt != S_IDLE);
    overrun_nxt = tick && (state != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      slot       <= '0;
      acc        <= '0;
      mv_req     <= 1'b0;
      mv_idx     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      detect_num <= '0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      acc        <= acc_nxt;
      mv_req     <= mv_req_nxt;
      mv_idx     <= mv_idx_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      overrun    <= overrun_nxt;
      detect_num <= detect_nxt;
    end
  end

`ifdef AI_SCHED_TIMEOUT_EN
  // Request-timeout counter and sticky error flag.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
      tmo_err <= tmo_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ai_scheduler.sv
// Self-checking bench for ai_scheduler. Stimulus pushes the expected
// request order and hit count per frame into queues. A negedge monitor
// pops them as the DUT raises mv_req and frame_done.
module tb_ai_scheduler;

  localparam int AI_NUM  = 4;
  localparam int COORD_W = 10;
  localparam int DET_R   = 64;
  localparam int TMO     = 15;

  logic                      clk_1 = 1'b0;
  logic                      rst;
  logic                      tick;
  logic [AI_NUM-1:0]         ai_enable;
  logic [COORD_W-1:0]        hero_x, hero_y;
  logic [COORD_W-1:0]        ax [AI_NUM];
  logic [COORD_W-1:0]        ay [AI_NUM];
  logic [AI_NUM*COORD_W-1:0] ai_x_flat, ai_y_flat;
  logic                      mv_req;
  logic [1:0]                mv_idx;
  logic                      mv_ack;
  logic                      busy, frame_done, overrun, tmo_err;
  logic [2:0]                detect_num;

  assign ai_x_flat = {ax[3], ax[2], ax[1], ax[0]};
  assign ai_y_flat = {ay[3], ay[2], ay[1], ay[0]};

  ai_scheduler #(
    .AI_NUM(AI_NUM), .COORD_W(COORD_W), .DET_R(DET_R), .TMO(TMO)
  ) dut (
    .clk_1(clk_1), .rst(rst), .tick(tick), .ai_enable(ai_enable),
    .hero_x(hero_x), .hero_y(hero_y),
    .ai_x_flat(ai_x_flat), .ai_y_flat(ai_y_flat),
    .mv_req(mv_req), .mv_idx(mv_idx), .mv_ack(mv_ack),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .detect_num(detect_num), .tmo_err(tmo_err)
  );

  always #5 clk_1 = ~clk_1;

  int errors = 0;
  int checks = 0;
  int exp_idx [$];
  int exp_det [$];
  int fd_count = 0;
  int ov_count = 0;
  int no_ack_idx = -1;
  int ack_delay = 2;
  bit ack_noise = 1'b0;
  int abandon_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count enabled slots whose AI lies within DET_R on both axes.
  function automatic int model_hits(input logic [AI_NUM-1:0] en, input int skip);
    int n = 0;
    for (int k = 0; k < AI_NUM; k++) begin
      int dx, dy;
      dx = int'(ax[k]) - int'(hero_x);
      dy = int'(ay[k]) - int'(hero_y);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (en[k] && k != skip && dx <= DET_R && dy <= DET_R) n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk_1);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic start_frame();
    for (int k = 0; k < AI_NUM; k++) if (ai_enable[k]) exp_idx.push_back(k);
    exp_det.push_back(model_hits(ai_enable, no_ack_idx));
    pulse_tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      step();
      n++;
    end
    chk("frame_end_busy", 32'(busy), 0);
  endtask

  task automatic wait_req(input int idx);
    int n = 0;
    while (!(mv_req === 1'b1 && int'(mv_idx) == idx) && n < 200) begin
      step();
      n++;
    end
    chk("wait_req_reached", 32'(n < 200), 1);
  endtask

  task automatic set_pos(input int k, input int x, input int y);
    ax[k] = COORD_W'(x);
    ay[k] = COORD_W'(y);
  endtask

  // Move-datapath responder: ack after ack_delay cycles, optional noise acks.
  initial begin
    int cnt = 0;
    mv_ack = 1'b0;
    forever begin
      @(negedge clk_1);
      if (rst !== 1'b1) begin
        mv_ack = 1'b0;
        cnt = 0;
      end else if (mv_ack) begin
        mv_ack = 1'b0;
        cnt = 0;
      end else if (mv_req) begin
        if (int'(mv_idx) != no_ack_idx) begin
          if (cnt >= ack_delay) mv_ack = 1'b1;
          else cnt++;
        end
      end else if (ack_noise && $urandom_range(3) == 0) begin
        mv_ack = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic       prev_req = 1'b0;
    logic [1:0] prev_idx = '0;
    int         cur_len = 0;
    forever begin
      @(negedge clk_1);
      if (rst !== 1'b1) begin
        prev_req = 1'b0;
        cur_len = 0;
      end else begin
        if (mv_req && !prev_req) begin
          if (exp_idx.size() == 0) chk("mv_req_unexpected", 1, 0);
          else chk("mv_idx", 32'(mv_idx), 32'(exp_idx.pop_front()));
        end
        if (mv_req && prev_req) chk("mv_idx_stable", 32'(mv_idx), 32'(prev_idx));
        if (mv_req) cur_len++;
        if (!mv_req && prev_req) begin
          if (int'(prev_idx) == no_ack_idx) abandon_len = cur_len;
          cur_len = 0;
        end
        if (frame_done) begin
          fd_count++;
          if (exp_det.size() == 0) chk("frame_done_unexpected", 1, 0);
          else chk("detect_num", 32'(detect_num), 32'(exp_det.pop_front()));
        end
        if (overrun) ov_count++;
        prev_req = mv_req;
        prev_idx = mv_idx;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ov0, fd0;
    rst = 1'b0;
    tick = 1'b0;
    ai_enable = '0;
    hero_x = '0;
    hero_y = '0;
    for (int k = 0; k < AI_NUM; k++) set_pos(k, 0, 0);
    #22;
    chk("rst_mv_req", 32'(mv_req), 0);
    chk("rst_mv_idx", 32'(mv_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_detect_num", 32'(detect_num), 0);
    chk("rst_tmo_err", 32'(tmo_err), 0);
    rst = 1'b1;
    step();
    step();

    // Full frame.
    ai_enable = 4'b1111;
    hero_x = 100; hero_y = 100;
    set_pos(0, 110, 90); set_pos(1, 300, 100); set_pos(2, 164, 36); set_pos(3, 165, 100);
    fd0 = fd_count;
    start_frame();
    wait_idle();
    chk("full_detect", 32'(detect_num), 2);
    chk("full_frame_done_once", 32'(fd_count - fd0), 1);

    // detect_num holds while idle even when positions change.
    set_pos(1, 100, 100);
    repeat (3) step();
    chk("detect_hold", 32'(detect_num), 2);
    set_pos(1, 300, 100);

    // All slots disabled: frame_done five cycles after tick; tick in DONE is an overrun.
    ai_enable = 4'b0000;
    exp_det.push_back(0);
    ov0 = ov_count;
    fd0 = fd_count;
    tick = 1'b1;
    step();
    tick = 1'b0;
    lat = 1;
    while (frame_done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("skip_latency", 32'(lat), 5);
    pulse_tick();
    repeat (3) step();
    chk("done_tick_overrun", 32'(ov_count - ov0), 1);
    chk("done_tick_not_queued", 32'(busy), 0);
    chk("skip_frame_done_once", 32'(fd_count - fd0), 1);
    chk("skip_detect", 32'(detect_num), 0);

    // Tick during REQ of slot 1 is dropped.
    ai_enable = 4'b1111;
    ov0 = ov_count;
    fd0 = fd_count;
    start_frame();
    wait_req(1);
    pulse_tick();
    wait_idle();
    repeat (2) step();
    chk("req_tick_overrun", 32'(ov_count - ov0), 1);
    chk("overrun_frame_done_once", 32'(fd_count - fd0), 1);
    chk("overrun_detect", 32'(detect_num), 2);

    // Boundary distances.
    hero_x = 100; hero_y = 100;
    set_pos(0, 164, 100); set_pos(1, 165, 100); set_pos(2, 100, 36); set_pos(3, 100, 35);
    start_frame();
    wait_idle();
    chk("boundary_detect_a", 32'(detect_num), 2);
    hero_x = 0; hero_y = 0;
    set_pos(0, 1023, 0); set_pos(1, 64, 64); set_pos(2, 0, 65); set_pos(3, 1023, 1023);
    start_frame();
    wait_idle();
    chk("boundary_detect_b", 32'(detect_num), 1);

    // Randomized frames, with stray acks outside requests.
    ack_noise = 1'b1;
    for (int f = 0; f < 25; f++) begin
      ai_enable = AI_NUM'($urandom);
      ack_delay = int'($urandom_range(3));
      hero_x = COORD_W'($urandom_range(1023));
      hero_y = COORD_W'($urandom_range(1023));
      for (int k = 0; k < AI_NUM; k++) begin
        int x, y;
        x = int'(hero_x) + int'($urandom_range(160)) - 80;
        y = int'(hero_y) + int'($urandom_range(160)) - 80;
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        set_pos(k, x, y);
      end
      start_frame();
      wait_idle();
      repeat (int'($urandom_range(2))) step();
    end
    ack_noise = 1'b0;
    ack_delay = 2;

    // Reset while slot 2 is being requested.
    ai_enable = 4'b1111;
    hero_x = 100; hero_y = 100;
    set_pos(0, 110, 90); set_pos(1, 300, 100); set_pos(2, 164, 36); set_pos(3, 165, 100);
    start_frame();
    wait_idle();
    chk("pre_reset_detect", 32'(detect_num), 2);
    fd0 = fd_count;
    start_frame();
    wait_req(2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_mv_req", 32'(mv_req), 0);
    chk("async_rst_detect", 32'(detect_num), 0);
    chk("async_rst_busy", 32'(busy), 0);
    exp_idx.delete();
    exp_det.delete();
    repeat (2) step();
    #3;
    rst = 1'b1;
    repeat (6) step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_mv_req", 32'(mv_req), 0);
    chk("post_rst_no_frame_done", 32'(fd_count - fd0), 0);

`ifdef AI_SCHED_TIMEOUT_EN
    // Slot 1 never acks: abandoned after TMO cycles and not counted.
    set_pos(1, 100, 100);
    no_ack_idx = 1;
    start_frame();
    wait_idle();
    chk("timeout_req_len", 32'(abandon_len), 32'(TMO));
    chk("timeout_tmo_err", 32'(tmo_err), 1);
    chk("timeout_detect", 32'(detect_num), 2);
    no_ack_idx = -1;
    start_frame();
    wait_idle();
    chk("timeout_sticky", 32'(tmo_err), 1);
    chk("after_timeout_detect", 32'(detect_num), 3);
`else
    chk("no_timeout_tmo_err", 32'(tmo_err), 0);
`endif

    repeat (3) step();
    chk("idx_queue_empty", 32'(exp_idx.size()), 0);
    chk("det_queue_empty", 32'(exp_det.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
